if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the fetch address loaded at reset.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-low.
REQ-004 The block SHALL have port stall, input, 1 bit: decode-stage hold request; freezes the PC and the IF/ID outputs.
REQ-005 The block SHALL have port br_taken, input, 1 bit: redirect request; flushes the fetched instruction.
REQ-006 The block SHALL have port br_target, input, 32 bits: redirect address; bits [1:0] are ignored and treated as 00.
REQ-007 The block SHALL have port imem_req, output, 1 bit: instruction memory read request.
REQ-008 The block SHALL have port imem_addr, output, 32 bits: word-aligned read address.
REQ-009 The block SHALL have port imem_ready, input, 1 bit: one-cycle pulse; imem_rdata is valid in that cycle.
REQ-010 The block SHALL have port imem_rdata, input, 32 bits: instruction word.
REQ-011 The block SHALL have port q_Instr, output, 32 bits: IF/ID registered instruction.
REQ-012 The block SHALL have port q_PCPlus4, output, 32 bits: IF/ID registered fetch address + 4.
REQ-013 The block SHALL have port q_Valid, output, 1 bit: IF/ID holds a real instruction; 0 means bubble.

Function
REQ-014 The block SHALL implement the states FETCH, STALLED and DRAIN, plus the registers pc (32 bits) and skid (32 bits).
REQ-015 The block SHALL drive imem_req=1 in FETCH and DRAIN and imem_req=0 in STALLED.
REQ-016 imem_addr SHALL equal pc in FETCH; in DRAIN it SHALL hold the address of the abandoned request.
REQ-017 While imem_req=1 and imem_ready=0, imem_addr SHALL be held stable.
REQ-018 In FETCH, with imem_ready=1, stall=0 and br_taken=0: q_Instr<=imem_rdata, q_PCPlus4<=pc+4, q_Valid<=1, pc<=pc+4; the state remains FETCH.
REQ-019 In FETCH, with imem_ready=1, stall=1 and br_taken=0: skid<=imem_rdata; pc, q_Instr, q_PCPlus4 and q_Valid are held; the state goes to STALLED.
REQ-020 In FETCH, with imem_ready=0, stall=0 and br_taken=0: q_Valid<=0 (bubble); q_Instr and q_PCPlus4 are held.
REQ-021 In FETCH, with imem_ready=0, stall=1 and br_taken=0: all IF/ID outputs and pc are held.
REQ-022 In STALLED, with stall=0 and br_taken=0: q_Instr<=skid, q_PCPlus4<=pc+4, q_Valid<=1, pc<=pc+4; the state goes to FETCH.
REQ-023 In STALLED, with stall=1: state, skid, pc and the IF/ID outputs are held.
REQ-024 br_taken=1 in any state SHALL set q_Valid<=0 and pc<={br_target[31:2],2'b00}, and SHALL discard skid and any imem_rdata returned that cycle; flush has priority over stall.
REQ-025 A redirect in FETCH with imem_ready=0 (request in flight) SHALL move the state to DRAIN; in every other case the state SHALL go to FETCH.
REQ-026 In DRAIN, the returning imem_ready pulse's data SHALL be discarded and the state SHALL go to FETCH; q_Valid stays 0 while in DRAIN.
REQ-027 A further br_taken while in DRAIN SHALL update pc only; the state remains DRAIN.
REQ-028 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC+4 = 32'h0000_0000), with no flag.
REQ-029 Latency: an instruction returned with imem_ready in cycle N SHALL appear on q_Instr in cycle N+1 when stall=0.

Reset
REQ-030 With rst=0 at a clock edge: state<=FETCH, pc<=RESET_PC, skid<=0, q_Instr<=0, q_PCPlus4<=0, q_Valid<=0; reset overrides stall and br_taken.
REQ-031 imem_req SHALL be 0 during any cycle in which rst=0.
REQ-032 Reset asserted mid-request or in DRAIN SHALL abandon the request; a stale imem_ready arriving after reset SHALL NOT be filtered, because the memory is reset together with this block.

Verification
REQ-033 Reset, then imem_ready=1 every cycle with rdata=addr^32'hA5A5A5A5 -> imem_addr sequence 0,4,8; q_Valid=1 from the 2nd edge; q_PCPlus4=4,8,12.
REQ-034 stall=1 for 3 cycles, coincident with ready for addr 8 -> the state enters STALLED and imem_req=0; on release q_Instr=rdata(8) and the next imem_addr is 12.
REQ-035 br_taken=1 with br_target=32'h0000_0103 while ready=0 -> DRAIN; the late ready data is discarded; the next imem_addr is 32'h0000_0100; q_Valid=0 throughout.
REQ-036 br_taken and stall both 1 while in STALLED -> q_Valid=0 next cycle; skid is not delivered; the state goes to FETCH at the target.
REQ-037 RESET_PC=32'hFFFF_FFFC with continuous ready -> q_PCPlus4=0 and the next imem_addr is 0 (wrap).
REQ-038 rst=0 asserted while in DRAIN -> the next cycle shows FETCH, imem_addr=RESET_PC, q_Valid=0 and all IF/ID outputs 0.

Source files
------------

// File: rtl/if_stage.sv
// Instruction fetch stage: issues word reads to instruction memory and fills the
// IF/ID register, with a one-entry skid for decode stalls and a drain state for redirects.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] q_Instr,
    output logic [31:0] q_PCPlus4,
    output logic        q_Valid,
    output logic [1:0]  dbgState
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        STALLED = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] skid;
    logic [31:0] drainAddr;
    logic [31:0] pcPlus4;
    logic [31:0] brPc;

    assign pcPlus4 = pc + 32'd4;
    assign brPc    = br_target & 32'hFFFF_FFFC;

    // Handshake: a request is open while imem_req=1; imem_addr stays fixed until the
    // cycle in which imem_ready pulses, and imem_rdata is taken only in that cycle.
    assign imem_req  = rst && (state != STALLED);
    assign imem_addr = (state == DRAIN) ? drainAddr : pc;
    assign dbgState  = state;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            skid      <= 32'd0;
            drainAddr <= 32'd0;
            q_Instr   <= 32'd0;
            q_PCPlus4 <= 32'd0;
            q_Valid   <= 1'b0;
        end else if (br_taken) begin
            q_Valid <= 1'b0;
            pc      <= brPc;
            skid    <= 32'd0;
            case (state)
                FETCH: begin
                    // A request still in flight must be waited out so its data is not
                    // mistaken for the first word at the new target.
                    if (!imem_ready) begin
                        state     <= DRAIN;
                        drainAddr <= pc;
                    end else begin
                        state <= FETCH;
                    end
                end
                DRAIN:   state <= imem_ready ? FETCH : DRAIN;
                default: state <= FETCH;
            endcase
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ready) begin
                        if (stall) begin
                            skid  <= imem_rdata;
                            state <= STALLED;
                        end else begin
                            q_Instr   <= imem_rdata;
                            q_PCPlus4 <= pcPlus4;
                            q_Valid   <= 1'b1;
                            pc        <= pcPlus4;
                        end
                    end else if (!stall) begin
                        q_Valid <= 1'b0;
                    end
                end
                STALLED: begin
                    if (!stall) begin
                        q_Instr   <= skid;
                        q_PCPlus4 <= pcPlus4;
                        q_Valid   <= 1'b1;
                        pc        <= pcPlus4;
                        state     <= FETCH;
                    end
                end
                DRAIN: begin
                    q_Valid <= 1'b0;
                    if (imem_ready) begin
                        state <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios for reset, stall, redirect, drain and wrap,
// then a random memory-latency / stall run checked against an in-order scoreboard.
module tb_if_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, br_taken, imem_ready;
  logic [31:0] br_target, imem_rdata;
  logic        imem_req, q_Valid;
  logic [31:0] imem_addr, q_Instr, q_PCPlus4;
  logic [1:0]  dbg_state;
  logic        imem_req2, q_Valid2;
  logic [31:0] imem_addr2, q_Instr2, q_PCPlus42;
  logic [1:0]  dbg_state2;

  localparam logic [1:0]  S_FETCH   = 2'd0;
  localparam logic [1:0]  S_STALLED = 2'd1;
  localparam logic [1:0]  S_DRAIN   = 2'd2;
  localparam logic [31:0] PAT       = 32'hA5A5_A5A5;

  if_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken), .br_target(br_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .q_Instr(q_Instr), .q_PCPlus4(q_PCPlus4),
    .q_Valid(q_Valid), .dbgState(dbg_state)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken), .br_target(br_target),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .q_Instr(q_Instr2), .q_PCPlus4(q_PCPlus42),
    .q_Valid(q_Valid2), .dbgState(dbg_state2)
  );

  int n_checks = 0;
  int n_fails  = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mw(input logic [31:0] a);
    return a ^ PAT;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] e;
    int wait_cnt;

    rst = 1'b0; stall = 1'b0; br_taken = 1'b0; imem_ready = 1'b0;
    br_target = 32'd0; imem_rdata = 32'd0;
    tick(); tick();
    check("rst_req", imem_req, 0);
    check("rst_valid", q_Valid, 0);
    check("rst_instr", q_Instr, 0);
    check("rst_pc4", q_PCPlus4, 0);
    check("rst_state", dbg_state, S_FETCH);
    check("rst_addr", imem_addr, 0);
    check("rst_addr_wrap", imem_addr2, 32'hFFFF_FFFC);

    rst = 1'b1; #1;
    check("rel_req", imem_req, 1);
    check("rel_addr", imem_addr, 0);

    // continuous ready
    imem_ready = 1'b1; imem_rdata = mw(32'd0); tick();
    check("seq0_valid", q_Valid, 1);
    check("seq0_instr", q_Instr, mw(32'd0));
    check("seq0_pc4", q_PCPlus4, 32'd4);
    check("seq0_addr", imem_addr, 32'd4);
    check("wrap_pc4", q_PCPlus42, 32'd0);
    check("wrap_addr", imem_addr2, 32'd0);
    imem_rdata = mw(32'd4); tick();
    check("seq1_instr", q_Instr, mw(32'd4));
    check("seq1_pc4", q_PCPlus4, 32'd8);
    check("seq1_addr", imem_addr, 32'd8);

    // stall coincident with ready for address 8
    stall = 1'b1; imem_rdata = mw(32'd8); tick();
    check("stl_state", dbg_state, S_STALLED);
    check("stl_req", imem_req, 0);
    check("stl_hold_instr", q_Instr, mw(32'd4));
    check("stl_hold_pc4", q_PCPlus4, 32'd8);
    imem_ready = 1'b0; tick();
    check("stl2_state", dbg_state, S_STALLED);
    check("stl2_req", imem_req, 0);
    tick();
    check("stl3_state", dbg_state, S_STALLED);
    stall = 1'b0; tick();
    check("unstl_instr", q_Instr, mw(32'd8));
    check("unstl_pc4", q_PCPlus4, 32'd12);
    check("unstl_valid", q_Valid, 1);
    check("unstl_state", dbg_state, S_FETCH);
    check("unstl_addr", imem_addr, 32'd12);

    // redirect with request in flight
    br_taken = 1'b1; br_target = 32'h0000_0103; tick();
    check("drn_state", dbg_state, S_DRAIN);
    check("drn_valid", q_Valid, 0);
    check("drn_addr", imem_addr, 32'd12);
    check("drn_req", imem_req, 1);
    br_taken = 1'b0; tick();
    check("drn2_state", dbg_state, S_DRAIN);
    check("drn2_addr", imem_addr, 32'd12);
    check("drn2_valid", q_Valid, 0);
    imem_ready = 1'b1; imem_rdata = mw(32'd12); tick();
    check("drn3_state", dbg_state, S_FETCH);
    check("drn3_valid", q_Valid, 0);
    check("drn3_addr", imem_addr, 32'h100);
    check("drn3_instr", q_Instr, mw(32'd8));

    // flush and stall together while STALLED
    stall = 1'b1; imem_rdata = mw(32'h100); tick();
    check("fs_state", dbg_state, S_STALLED);
    imem_ready = 1'b0; br_taken = 1'b1; br_target = 32'h40; tick();
    check("fs_valid", q_Valid, 0);
    check("fs_state2", dbg_state, S_FETCH);
    check("fs_addr", imem_addr, 32'h40);
    br_taken = 1'b0; stall = 1'b0; imem_ready = 1'b1; imem_rdata = mw(32'h40); tick();
    check("fs_instr", q_Instr, mw(32'h40));
    check("fs_pc4", q_PCPlus4, 32'h44);
    check("fs_valid2", q_Valid, 1);

    // second redirect while draining
    imem_ready = 1'b0; br_taken = 1'b1; br_target = 32'h300; tick();
    check("rd_state", dbg_state, S_DRAIN);
    check("rd_addr", imem_addr, 32'h44);
    br_target = 32'h502; tick();
    check("rd2_state", dbg_state, S_DRAIN);
    check("rd2_addr", imem_addr, 32'h44);
    br_taken = 1'b0; imem_ready = 1'b1; imem_rdata = mw(32'h44); tick();
    check("rd3_state", dbg_state, S_FETCH);
    check("rd3_addr", imem_addr, 32'h500);
    check("rd3_valid", q_Valid, 0);

    // reset while draining
    imem_ready = 1'b0; br_taken = 1'b1; br_target = 32'h80; tick();
    check("rdr_state", dbg_state, S_DRAIN);
    br_taken = 1'b0; rst = 1'b0; tick();
    check("rdr_state2", dbg_state, S_FETCH);
    check("rdr_addr", imem_addr, 32'd0);
    check("rdr_valid", q_Valid, 0);
    check("rdr_instr", q_Instr, 0);
    check("rdr_pc4", q_PCPlus4, 0);
    check("rdr_req", imem_req, 0);
    rst = 1'b1;

    // random latency and stalls, every returned word delivered in order
    wait_cnt = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      stall = ($urandom_range(0, 3) == 0);
      if (q_Valid && !stall) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("sb_instr", q_Instr, e[31:0]);
          check("sb_pc4", q_PCPlus4, e[63:32]);
        end
      end
      if (imem_req && wait_cnt == 0) begin
        imem_ready = 1'b1;
        imem_rdata = mw(imem_addr);
        exp_q.push_back({imem_addr + 32'd4, mw(imem_addr)});
        wait_cnt = $urandom_range(0, 2);
      end else begin
        imem_ready = 1'b0;
        if (imem_req && wait_cnt > 0) wait_cnt--;
      end
    end
    check("sb_backlog", (exp_q.size() <= 2) ? 32'd1 : 32'd0, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
